// File: rtl/snake_body_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snake_body_store_pkg
//  Purpose  : Shared types and constants for the snake body store and the
//             renderer that walks it: direction encodings, body-store FSM
//             states, the reverse-direction helper and the coordinate /
//             length / index widths both sides must agree on.
//  Ports    : (package, no ports)
//  Revision : 1.0  initial release
// ============================================================================
package snake_body_store_pkg;

  localparam int SNK_X_BITS   = 6;
  localparam int SNK_Y_BITS   = 6;
  localparam int SNK_LEN_W    = 8;
  localparam int SNK_ADDR_W   = 8;
  localparam int SNK_INIT_LEN = 3;

  // Encoding pairs opposite directions so that reverse is a flip of bit 0.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_MOVE   = 3'd2,
    ST_SCAN   = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  function automatic dir_e reverse_dir(input dir_e d);
    dir_e r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      default:   r = DIR_LEFT;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_body_store_dir_step.sv
`default_nettype none
// ============================================================================
//  Module   : snake_dir_step
//  Purpose  : Combinational next-head calculator. Moves the head one cell in
//             the given direction and reports when that move would leave the
//             playfield (below 0 or above max_x / max_y). On a wall hit the
//             returned head equals the input head.
//  Ports    : head_x/head_y  in   current head
//             dir            in   effective direction
//             max_x/max_y    in   largest legal coordinates
//             new_x/new_y    out  head after the move
//             wall_hit       out  move would cross a wall
//  Revision : 1.0  initial release
// ============================================================================
module snake_dir_step
  import snake_body_store_pkg::*;
#(
  parameter int X_BITS = SNK_X_BITS,
  parameter int Y_BITS = SNK_Y_BITS
) (
  input  logic [X_BITS-1:0] head_x,
  input  logic [Y_BITS-1:0] head_y,
  input  dir_e              dir,
  input  logic [X_BITS-1:0] max_x,
  input  logic [Y_BITS-1:0] max_y,
  output logic [X_BITS-1:0] new_x,
  output logic [Y_BITS-1:0] new_y,
  output logic              wall_hit
);

  always_comb begin
    new_x    = head_x;
    new_y    = head_y;
    wall_hit = 1'b0;
    case (dir)
      DIR_UP: begin
        if (head_y == '0) wall_hit = 1'b1;
        else              new_y    = head_y - Y_BITS'(1);
      end
      DIR_DOWN: begin
        // >= rather than == so a shrunken playfield still reports the wall
        if (head_y >= max_y) wall_hit = 1'b1;
        else                 new_y    = head_y + Y_BITS'(1);
      end
      DIR_LEFT: begin
        if (head_x == '0) wall_hit = 1'b1;
        else              new_x    = head_x - X_BITS'(1);
      end
      default: begin
        if (head_x >= max_x) wall_hit = 1'b1;
        else                 new_x    = head_x + X_BITS'(1);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/snake_body_store.sv
`default_nettype none
// ============================================================================
//  Module   : snake_body_store
//  Purpose  : Holds the snake body as a circular buffer (logical index 0 is
//             the head) and executes init / step operations: new-head
//             calculation, wall check, serial self-collision scan and an
//             atomic commit. Serves the renderer's zero-latency segment query.
//  Ports    : clk, rst            clock, asynchronous active-high reset
//             init, init_x/init_y load a fresh snake headed at (init_x,init_y)
//             step, dir, grow     advance one cell (dir/grow sampled with step)
//             max_x, max_y        playfield limits
//             q_addr -> q_x/q_y/q_vld   combinational segment query
//             hx, hy, len         committed head and length
//             busy, done, hit     status: operation running, finish pulse,
//                                 sticky collision
//  Revision : 1.0  initial release
// ============================================================================
module snake_body_store
  import snake_body_store_pkg::*;
#(
  parameter int X_BITS   = SNK_X_BITS,
  parameter int Y_BITS   = SNK_Y_BITS,
  parameter int S_LEN_W  = SNK_LEN_W,
  parameter int S_ADDR_W = SNK_ADDR_W,
  parameter int INIT_LEN = SNK_INIT_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic [X_BITS-1:0]   init_x,
  input  logic [Y_BITS-1:0]   init_y,
  input  logic                step,
  input  logic [1:0]          dir,
  input  logic                grow,
  input  logic [X_BITS-1:0]   max_x,
  input  logic [Y_BITS-1:0]   max_y,
  input  logic [S_ADDR_W-1:0] q_addr,
  output logic [X_BITS-1:0]   q_x,
  output logic [Y_BITS-1:0]   q_y,
  output logic                q_vld,
  output logic [X_BITS-1:0]   hx,
  output logic [Y_BITS-1:0]   hy,
  output logic [S_LEN_W-1:0]  len,
  output logic                busy,
  output logic                done,
  output logic                hit
);

  localparam int MAX_LEN = 2 ** S_ADDR_W;
  // Largest length the counter can actually hold; growth saturates here.
  localparam int LEN_FULL = (MAX_LEN < (2 ** S_LEN_W) - 1) ? MAX_LEN : (2 ** S_LEN_W) - 1;
  localparam logic [S_LEN_W-1:0] LEN_FULL_L = S_LEN_W'(LEN_FULL);
  localparam logic [S_LEN_W-1:0] INIT_LEN_L = S_LEN_W'(INIT_LEN);
  localparam logic [S_LEN_W-1:0] INIT_LAST  = S_LEN_W'(INIT_LEN - 1);
  // The initial body extends to the left, so the head must leave room for it.
  localparam logic [X_BITS-1:0]  INIT_X_MIN = X_BITS'(INIT_LEN - 1);
  localparam int CMP_W = ((S_ADDR_W > S_LEN_W) ? S_ADDR_W : S_LEN_W) + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                state_q,    state_d;
  logic [S_ADDR_W-1:0]   head_ptr_q, head_ptr_d;
  logic [S_LEN_W-1:0]    len_q,      len_d;
  logic [X_BITS-1:0]     hx_q,       hx_d;
  logic [Y_BITS-1:0]     hy_q,       hy_d;
  dir_e                  cur_dir_q,  cur_dir_d;
  logic                  hit_q,      hit_d;
  logic                  done_q,     done_d;
  logic [S_LEN_W-1:0]    cnt_q,      cnt_d;      // INIT write index / SCAN index
  logic [S_LEN_W-1:0]    lim_q,      lim_d;      // number of SCAN compares
  logic [X_BITS-1:0]     nx_q,       nx_d;       // pending new head
  logic [Y_BITS-1:0]     ny_q,       ny_d;
  dir_e                  eff_dir_q,  eff_dir_d;
  logic                  grow_eff_q, grow_eff_d;
  dir_e                  req_dir_q,  req_dir_d;  // dir/grow captured with step
  logic                  req_grow_q, req_grow_d;
  logic [X_BITS-1:0]     ix_q,       ix_d;       // init head (after clamp)
  logic [Y_BITS-1:0]     iy_q,       iy_d;

  logic [X_BITS-1:0]     seg_x_q [MAX_LEN];
  logic [Y_BITS-1:0]     seg_y_q [MAX_LEN];

  logic                  seg_we;
  logic [S_ADDR_W-1:0]   seg_wa;
  logic [X_BITS-1:0]     seg_wx;
  logic [Y_BITS-1:0]     seg_wy;

  // --------------------------------------------------------------------------
  // Query port and scan read: logical -> physical with natural wrap
  // --------------------------------------------------------------------------
  logic [S_ADDR_W-1:0] q_phys;
  logic [S_ADDR_W-1:0] scan_phys;
  logic [X_BITS-1:0]   scan_x;
  logic [Y_BITS-1:0]   scan_y;

  assign q_phys    = head_ptr_q + q_addr;
  assign q_x       = seg_x_q[q_phys];
  assign q_y       = seg_y_q[q_phys];
  assign q_vld     = CMP_W'(q_addr) < CMP_W'(len_q);

  assign scan_phys = head_ptr_q + S_ADDR_W'(cnt_q);
  assign scan_x    = seg_x_q[scan_phys];
  assign scan_y    = seg_y_q[scan_phys];

  // --------------------------------------------------------------------------
  // Move evaluation
  // --------------------------------------------------------------------------
  dir_e                move_dir;
  logic [X_BITS-1:0]   step_x;
  logic [Y_BITS-1:0]   step_y;
  logic                step_wall;
  logic                move_grow;
  logic [S_LEN_W-1:0]  move_lim;
  logic [S_ADDR_W-1:0] ptr_dec;

  // A single-cell snake may turn around; a longer one would bite its neck.
  assign move_dir  = ((req_dir_q == reverse_dir(cur_dir_q)) && (len_q > S_LEN_W'(1)))
                     ? cur_dir_q : req_dir_q;
  assign move_grow = req_grow_q && (len_q < LEN_FULL_L);
  // Without growth the tail leaves its cell this tick, so it is not scanned.
  // An empty body has nothing to collide with.
  assign move_lim  = (len_q == '0) ? '0 :
                     (move_grow ? len_q : len_q - S_LEN_W'(1));
  assign ptr_dec   = head_ptr_q - S_ADDR_W'(1);

  snake_dir_step #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_dir_step (
    .head_x   (hx_q),
    .head_y   (hy_q),
    .dir      (move_dir),
    .max_x    (max_x),
    .max_y    (max_y),
    .new_x    (step_x),
    .new_y    (step_y),
    .wall_hit (step_wall)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    head_ptr_d = head_ptr_q;
    len_d      = len_q;
    hx_d       = hx_q;
    hy_d       = hy_q;
    cur_dir_d  = cur_dir_q;
    hit_d      = hit_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    lim_d      = lim_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    eff_dir_d  = eff_dir_q;
    grow_eff_d = grow_eff_q;
    req_dir_d  = req_dir_q;
    req_grow_d = req_grow_q;
    ix_d       = ix_q;
    iy_d       = iy_q;
    seg_we     = 1'b0;
    seg_wa     = head_ptr_q;
    seg_wx     = nx_q;
    seg_wy     = ny_q;

    if (init) begin
      // init preempts anything in flight; an aborted step never commits.
      state_d    = ST_INIT;
      len_d      = '0;
      hit_d      = 1'b0;
      head_ptr_d = '0;
      cur_dir_d  = DIR_RIGHT;
      cnt_d      = '0;
      ix_d       = (init_x < INIT_X_MIN) ? INIT_X_MIN : init_x;
      iy_d       = init_y;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (step && !hit_q) begin
            state_d    = ST_MOVE;
            req_dir_d  = dir_e'(dir);
            req_grow_d = grow;
          end
        end

        ST_INIT: begin
          // head_ptr is 0 throughout INIT, so logical k == physical k
          seg_we = 1'b1;
          seg_wa = S_ADDR_W'(cnt_q);
          seg_wx = ix_q - X_BITS'(cnt_q);
          seg_wy = iy_q;
          if (cnt_q == INIT_LAST) begin
            len_d   = INIT_LEN_L;
            hx_d    = ix_q;
            hy_d    = iy_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + S_LEN_W'(1);
          end
        end

        ST_MOVE: begin
          if (step_wall) begin
            hit_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            nx_d       = step_x;
            ny_d       = step_y;
            eff_dir_d  = move_dir;
            grow_eff_d = move_grow;
            lim_d      = move_lim;
            cnt_d      = '0;
            state_d    = (move_lim == '0) ? ST_COMMIT : ST_SCAN;
          end
        end

        ST_SCAN: begin
          if ((scan_x == nx_q) && (scan_y == ny_q)) begin
            hit_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (cnt_q == lim_q - S_LEN_W'(1)) begin
            state_d = ST_COMMIT;
          end else begin
            cnt_d = cnt_q + S_LEN_W'(1);
          end
        end

        ST_COMMIT: begin
          // Prepending in front of the head: the old tail slot is simply
          // dropped by len when not growing.
          head_ptr_d = ptr_dec;
          seg_we     = 1'b1;
          seg_wa     = ptr_dec;
          seg_wx     = nx_q;
          seg_wy     = ny_q;
          len_d      = len_q + S_LEN_W'(grow_eff_q);
          hx_d       = nx_q;
          hy_d       = ny_q;
          cur_dir_d  = eff_dir_q;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      head_ptr_q <= '0;
      len_q      <= '0;
      hx_q       <= '0;
      hy_q       <= '0;
      cur_dir_q  <= DIR_RIGHT;
      hit_q      <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      lim_q      <= '0;
      nx_q       <= '0;
      ny_q       <= '0;
      eff_dir_q  <= DIR_RIGHT;
      grow_eff_q <= 1'b0;
      req_dir_q  <= DIR_RIGHT;
      req_grow_q <= 1'b0;
      ix_q       <= '0;
      iy_q       <= '0;
    end else begin
      state_q    <= state_d;
      head_ptr_q <= head_ptr_d;
      len_q      <= len_d;
      hx_q       <= hx_d;
      hy_q       <= hy_d;
      cur_dir_q  <= cur_dir_d;
      hit_q      <= hit_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      lim_q      <= lim_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      eff_dir_q  <= eff_dir_d;
      grow_eff_q <= grow_eff_d;
      req_dir_q  <= req_dir_d;
      req_grow_q <= req_grow_d;
      ix_q       <= ix_d;
      iy_q       <= iy_d;
    end
  end

  // Segment storage carries no reset; contents are meaningless until init.
  always_ff @(posedge clk) begin
    if (seg_we) begin
      seg_x_q[seg_wa] <= seg_wx;
      seg_y_q[seg_wa] <= seg_wy;
    end
  end

  assign hx   = hx_q;
  assign hy   = hy_q;
  assign len  = len_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hit  = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_store.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_snake_body_store
//  Purpose  : Directed self-checking bench for snake_body_store.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snake_body_store;
  import snake_body_store_pkg::*;

  localparam int XB = 6;
  localparam int YB = 6;
  localparam int LW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init = 1'b0;
  logic [XB-1:0] init_x = '0;
  logic [YB-1:0] init_y = '0;
  logic          step = 1'b0;
  logic [1:0]    dir = 2'd3;
  logic          grow = 1'b0;
  logic [XB-1:0] max_x = 6'd59;
  logic [YB-1:0] max_y = 6'd39;
  logic [AW-1:0] q_addr = '0;
  logic [XB-1:0] q_x;
  logic [YB-1:0] q_y;
  logic          q_vld;
  logic [XB-1:0] hx;
  logic [YB-1:0] hy;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          hit;

  int errors = 0;
  int checks = 0;

  snake_body_store #(
    .X_BITS(XB), .Y_BITS(YB), .S_LEN_W(LW), .S_ADDR_W(AW), .INIT_LEN(3)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .init_x(init_x), .init_y(init_y),
    .step(step), .dir(dir), .grow(grow), .max_x(max_x), .max_y(max_y),
    .q_addr(q_addr), .q_x(q_x), .q_y(q_y), .q_vld(q_vld),
    .hx(hx), .hy(hy), .len(len), .busy(busy), .done(done), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accepting edge until done; -1 on timeout.
  task automatic wait_done(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic do_init(input logic [XB-1:0] x, input logic [YB-1:0] y);
    init = 1'b1; init_x = x; init_y = y;
    tick();
    init = 1'b0;
  endtask

  task automatic do_step(input logic [1:0] d, input logic g);
    step = 1'b1; dir = d; grow = g;
    tick();
    step = 1'b0; grow = 1'b0;
  endtask

  task automatic query(input logic [AW-1:0] a, output logic [XB-1:0] x,
                       output logic [YB-1:0] y, output logic v);
    q_addr = a;
    #1;
    x = q_x; y = q_y; v = q_vld;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    tick(); tick();
    checks++;
    if ({len, hx, hy} !== {8'd0, 6'd0, 6'd0}) begin
      errors++; $display("FAIL reset_state: len=%0d hx=%0d hy=%0d want 0/0/0", len, hx, hy);
    end
    checks++;
    if ({busy, done, hit} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: busy/done/hit=%b want 000", {busy, done, hit});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_init();
    int n; logic [XB-1:0] x; logic [YB-1:0] y; logic v;
    do_init(6'd10, 6'd5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b want 1", busy); end
    wait_done(20, n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL init_latency: got %0d want 3", n); end
    checks++;
    if ({len, hx, hy} !== {8'd3, 6'd10, 6'd5}) begin
      errors++; $display("FAIL init_head: len=%0d hx=%0d hy=%0d want 3/10/5", len, hx, hy);
    end
    for (int k = 0; k < 3; k++) begin
      query(AW'(k), x, y, v);
      checks++;
      if ({v, x, y} !== {1'b1, 6'(10 - k), 6'd5}) begin
        errors++; $display("FAIL init_q%0d: got v=%b (%0d,%0d) want v=1 (%0d,5)", k, v, x, y, 10 - k);
      end
    end
    query(8'd3, x, y, v);
    checks++;
    if (v !== 1'b0) begin errors++; $display("FAIL init_q3_vld: got %b want 0", v); end
  endtask

  task automatic test_step_right();
    int n; logic [XB-1:0] x; logic [YB-1:0] y; logic v;
    do_step(DIR_RIGHT, 1'b0);
    // Mid-operation query still sees the committed snake
    query(8'd0, x, y, v);
    checks++;
    if ({busy, v, x, y} !== {1'b1, 1'b1, 6'd10, 6'd5}) begin
      errors++; $display("FAIL busy_query: got busy=%b v=%b (%0d,%0d) want 1 1 (10,5)", busy, v, x, y);
    end
    wait_done(20, n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL step_latency: got %0d want 4", n); end
    checks++;
    if ({len, hx, hy, hit} !== {8'd3, 6'd11, 6'd5, 1'b0}) begin
      errors++; $display("FAIL step_head: len=%0d (%0d,%0d) hit=%b want 3 (11,5) 0", len, hx, hy, hit);
    end
    query(8'd2, x, y, v);
    checks++;
    if ({v, x, y} !== {1'b1, 6'd9, 6'd5}) begin
      errors++; $display("FAIL step_tail: got v=%b (%0d,%0d) want 1 (9,5)", v, x, y);
    end
  endtask

  task automatic test_reverse_grow();
    int n; logic [XB-1:0] x; logic [YB-1:0] y; logic v;
    do_step(DIR_LEFT, 1'b1);
    wait_done(20, n);
    checks++;
    if (n != 5) begin errors++; $display("FAIL rev_latency: got %0d want 5", n); end
    checks++;
    if ({len, hx, hy} !== {8'd4, 6'd12, 6'd5}) begin
      errors++; $display("FAIL rev_head: len=%0d (%0d,%0d) want 4 (12,5)", len, hx, hy);
    end
    query(8'd3, x, y, v);
    checks++;
    if ({v, x, y} !== {1'b1, 6'd9, 6'd5}) begin
      errors++; $display("FAIL rev_tail: got v=%b (%0d,%0d) want 1 (9,5)", v, x, y);
    end
    query(8'd4, x, y, v);
    checks++;
    if (v !== 1'b0) begin errors++; $display("FAIL rev_q4_vld: got %b want 0", v); end
  endtask

  task automatic test_clamp();
    int n; logic [XB-1:0] x; logic [YB-1:0] y; logic v;
    do_init(6'd0, 6'd7);
    wait_done(20, n);
    query(8'd2, x, y, v);
    checks++;
    if ({hx, hy, v, x, y} !== {6'd2, 6'd7, 1'b1, 6'd0, 6'd7}) begin
      errors++; $display("FAIL init_clamp: head (%0d,%0d) tail v=%b (%0d,%0d) want (2,7) 1 (0,7)", hx, hy, v, x, y);
    end
  endtask

  task automatic test_wall();
    int n; int seen;
    do_init(6'd59, 6'd20);
    wait_done(20, n);
    do_step(DIR_RIGHT, 1'b0);
    wait_done(20, n);
    checks++;
    if (n != 1) begin errors++; $display("FAIL wall_latency: got %0d want 1", n); end
    checks++;
    if ({hit, len, hx, hy} !== {1'b1, 8'd3, 6'd59, 6'd20}) begin
      errors++; $display("FAIL wall_right: hit=%b len=%0d (%0d,%0d) want 1 3 (59,20)", hit, len, hx, hy);
    end
    // With hit set, steps are ignored entirely
    do_step(DIR_UP, 1'b0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL wall_ignore: got %0d busy/done cycles want 0", seen); end
    do_init(6'd10, 6'd0);
    wait_done(20, n);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL init_clears_hit: got %b want 0", hit); end
    do_step(DIR_UP, 1'b0);
    wait_done(20, n);
    checks++;
    if ({n, hit, hy} !== {32'sd1, 1'b1, 6'd0}) begin
      errors++; $display("FAIL wall_top: n=%0d hit=%b hy=%0d want 1 1 0", n, hit, hy);
    end
  endtask

  // Square loop: up, left, down, right on a 4-long snake. Without growth the
  // last two moves land on the cell the tail is vacating.
  task automatic test_tail_chase();
    int n; logic [XB-1:0] x; logic [YB-1:0] y; logic v;
    logic [1:0] seq [4];
    seq[0] = DIR_UP; seq[1] = DIR_LEFT; seq[2] = DIR_DOWN; seq[3] = DIR_RIGHT;
    for (int pass = 0; pass < 2; pass++) begin
      do_init(6'd10, 6'd5);
      wait_done(20, n);
      do_step(DIR_RIGHT, 1'b1);
      wait_done(20, n);
      for (int s = 0; s < 4; s++) begin
        do_step(seq[s], (pass == 1) && (s == 3));
        wait_done(20, n);
        if (s == 2) begin
          checks++;
          if ({hit, hx, hy} !== {1'b0, 6'd10, 6'd5}) begin
            errors++; $display("FAIL chase%0d_down: hit=%b (%0d,%0d) want 0 (10,5)", pass, hit, hx, hy);
          end
        end
      end
      if (pass == 0) begin
        query(8'd3, x, y, v);
        checks++;
        if ({hit, len, hx, hy, v, x, y} !== {1'b0, 8'd4, 6'd11, 6'd5, 1'b1, 6'd11, 6'd4}) begin
          errors++; $display("FAIL chase_nogrow: hit=%b len=%0d (%0d,%0d) tail (%0d,%0d) want 0 4 (11,5) (11,4)",
                             hit, len, hx, hy, x, y);
        end
      end else begin
        checks++;
        if ({hit, len, hx, hy} !== {1'b1, 8'd4, 6'd10, 6'd5}) begin
          errors++; $display("FAIL chase_grow: hit=%b len=%0d (%0d,%0d) want 1 4 (10,5)", hit, len, hx, hy);
        end
      end
    end
  endtask

  task automatic test_init_priority();
    int n; logic [XB-1:0] x; logic [YB-1:0] y; logic v;
    init = 1'b1; init_x = 6'd20; init_y = 6'd9;
    step = 1'b1; dir = DIR_UP;
    tick();
    init = 1'b0; step = 1'b0;
    wait_done(20, n);
    checks++;
    if ({n, len, hx, hy, hit} !== {32'sd3, 8'd3, 6'd20, 6'd9, 1'b0}) begin
      errors++; $display("FAIL init_vs_step: n=%0d len=%0d (%0d,%0d) hit=%b want 3 3 (20,9) 0", n, len, hx, hy, hit);
    end
    do_step(DIR_RIGHT, 1'b0);
    tick();                       // now scanning
    do_init(6'd30, 6'd12);
    wait_done(20, n);
    query(8'd1, x, y, v);
    checks++;
    if ({n, len, hx, hy, v, x, y} !== {32'sd3, 8'd3, 6'd30, 6'd12, 1'b1, 6'd29, 6'd12}) begin
      errors++; $display("FAIL init_mid_scan: n=%0d len=%0d (%0d,%0d) q1 (%0d,%0d) want 3 3 (30,12) (29,12)",
                         n, len, hx, hy, x, y);
    end
  endtask

  task automatic test_rst_mid_scan();
    do_step(DIR_DOWN, 1'b0);
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL scan_busy: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    checks++;
    if ({len, busy, hx, hy, done} !== {8'd0, 1'b0, 6'd0, 6'd0, 1'b0}) begin
      errors++; $display("FAIL rst_mid_scan: len=%0d busy=%b (%0d,%0d) done=%b want 0 0 (0,0) 0", len, busy, hx, hy, done);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_init();
    test_step_right();
    test_reverse_grow();
    test_clamp();
    test_wall();
    test_tail_chase();
    test_init_priority();
    test_rst_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
